instr_encoder_loader: RTL and testbench

Packs instruction fields (opcode, Rd, Rs, imm2, imm4) into 8-bit instruction bytes and streams them into program memory at consecutive addresses. It is the inverse of the core's field decoder. It sits between the test/boot host interface and the instruction memory write port, and loads a program before the CPU is released. Supports a valid/ready input handshake, memory back-pressure, capacity tracking and sticky error flags.

---
 rtl/instr_pkg.sv | 43 ++++
 rtl/instr_encoder_loader_if.sv | 40 ++++
 rtl/instr_encoder_loader_packer.sv | 36 +++
 rtl/instr_encoder_loader.sv | 142 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// Shared instruction-set definitions: opcode values, encoding formats, format lookup.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Used by the encoder/loader, the core's field decoder and the control unit.
package instr_pkg;

    // Opcode values. The format split below is the only property the loader cares about.
    localparam logic [3:0] OPC_0 = 4'h0;
    localparam logic [3:0] OPC_1 = 4'h1;
    localparam logic [3:0] OPC_2 = 4'h2;
    localparam logic [3:0] OPC_3 = 4'h3;
    localparam logic [3:0] OPC_4 = 4'h4;
    localparam logic [3:0] OPC_5 = 4'h5;
    localparam logic [3:0] OPC_6 = 4'h6;
    localparam logic [3:0] OPC_7 = 4'h7;
    localparam logic [3:0] OPC_8 = 4'h8;
    localparam logic [3:0] OPC_9 = 4'h9;
    localparam logic [3:0] OPC_A = 4'hA;
    localparam logic [3:0] OPC_B = 4'hB;
    localparam logic [3:0] OPC_C = 4'hC;
    localparam logic [3:0] OPC_D = 4'hD;
    localparam logic [3:0] OPC_E = 4'hE;
    localparam logic [3:0] OPC_F = 4'hF;

    // Low-nibble layout of an instruction byte.
    typedef enum logic [1:0] {
        FMT_IMM4 = 2'd0,  // {opcode, imm4}
        FMT_RI   = 2'd1,  // {opcode, rd, imm2}
        FMT_RR   = 2'd2   // {opcode, rd, rs}
    } fmt_e;

    function automatic fmt_e fmt_of(input logic [3:0] opcode);
        fmt_e f;
        case (opcode)
            OPC_0, OPC_1:                             f = FMT_IMM4;
            OPC_2, OPC_9, OPC_B, OPC_C, OPC_D,
            OPC_E, OPC_F:                             f = FMT_RI;
            default:                                  f = FMT_RR;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Handshake bundles of the loader: field-tuple input and memory write port.
// Latency: n/a (wiring only).
// Backpressure: in_ready / mem_ready flow from slave back to master.
// instr_fields_if: in_valid/in_ready + opcode, rd, rs, imm2, imm4 (master = host).
// instr_mem_if:    mem_we/mem_addr/mem_wdata + mem_ready (master = loader).

interface instr_fields_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode;
    logic [1:0] in_rd;
    logic [1:0] in_rs;
    logic [1:0] in_imm2;
    logic [3:0] in_imm4;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs, in_imm2, in_imm4,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs, in_imm2, in_imm4,
        output in_ready
    );
endinterface

interface instr_mem_if #(parameter int ADDR_W = 8);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ready;

    modport master (
        output mem_we, mem_addr, mem_wdata,
        input  mem_ready
    );
    modport slave (
        input  mem_we, mem_addr, mem_wdata,
        output mem_ready
    );
endinterface

// File: rtl/instr_encoder_loader_packer.sv
// Packs instruction fields into one byte and flags nonzero fields the format ignores.
// Latency: combinational.
// Backpressure: none (no state).
// Ports: opcode_i/rd_i/rs_i/imm2_i/imm4_i in; byte_o (encoded), field_err_o out.
module instr_field_packer
    import instr_pkg::*;
(
    input  logic [3:0] opcode_i,
    input  logic [1:0] rd_i,
    input  logic [1:0] rs_i,
    input  logic [1:0] imm2_i,
    input  logic [3:0] imm4_i,
    output logic [7:0] byte_o,
    output logic       field_err_o
);

    always_comb begin
        byte_o      = {opcode_i, imm4_i};
        field_err_o = 1'b0;
        case (fmt_of(opcode_i))
            FMT_IMM4: begin
                byte_o      = {opcode_i, imm4_i};
                field_err_o = |{rd_i, rs_i, imm2_i};
            end
            FMT_RI: begin
                byte_o      = {opcode_i, rd_i, imm2_i};
                field_err_o = |{rs_i, imm4_i};
            end
            default: begin
                byte_o      = {opcode_i, rd_i, rs_i};
                field_err_o = |{imm2_i, imm4_i};
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes field tuples and streams the bytes into program memory at consecutive addresses.
// Latency: tuple accepted at edge N is on mem_we/addr/wdata from cycle N+1; 1 byte/cycle.
// Backpressure: in_ready drops when memory is full or the output register is stalled by mem_ready.
// Ports: clk, rst (sync, active-high); start_i/finish_i session control; in_if (slave) field
// tuples; mem_if (master) write port; busy_o, done_o, count_o, overflow_o, field_err_o status.
module instr_encoder_loader
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            finish_i,
    instr_fields_if.slave   in_if,
    instr_mem_if.master     mem_if,
    output logic            busy_o,
    output logic            done_o,
    output logic [ADDR_W:0] count_o,
    output logic            overflow_o,
    output logic            field_err_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              out_vld_q, out_vld_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [7:0]        out_dat_q, out_dat_d;
    logic              overflow_q, overflow_d;
    logic              field_err_q, field_err_d;

    logic [7:0] pk_byte;
    logic       pk_err;
    logic       in_load;
    logic       full;
    logic       session_open;
    logic       in_rdy;
    logic       accept;
    logic       wr_done;

    instr_field_packer u_packer (
        .opcode_i    (in_if.in_opcode),
        .rd_i        (in_if.in_rd),
        .rs_i        (in_if.in_rs),
        .imm2_i      (in_if.in_imm2),
        .imm4_i      (in_if.in_imm4),
        .byte_o      (pk_byte),
        .field_err_o (pk_err)
    );

    // Pointer is one bit wider than the address so "all 2**ADDR_W slots used"
    // is distinguishable from "empty"; it never advances past that value.
    assign full         = wr_ptr_q[ADDR_W];
    assign in_load      = (state_q == ST_LOAD);
    assign session_open = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // The output register can take a new byte in the same cycle its current one retires.
    assign in_rdy       = in_load && !full && (!out_vld_q || mem_if.mem_ready);
    assign accept       = in_if.in_valid && in_rdy;
    assign wr_done      = out_vld_q && mem_if.mem_ready;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        out_vld_d   = out_vld_q;
        out_addr_d  = out_addr_q;
        out_dat_d   = out_dat_q;
        overflow_d  = overflow_q;
        field_err_d = field_err_q;

        case (state_q)
            ST_IDLE, ST_DONE: if (start_i)    state_d = ST_LOAD;
            ST_LOAD:          if (finish_i)   state_d = ST_DRAIN;
            // Leaving DRAIN only once the register is observed empty keeps DONE
            // at least one cycle behind the final write completion.
            ST_DRAIN:         if (!out_vld_q) state_d = ST_DONE;
            default:                          state_d = ST_IDLE;
        endcase

        if (session_open) begin
            wr_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            field_err_d = 1'b0;
        end else begin
            if (accept)                           wr_ptr_d    = wr_ptr_q + PTR_ONE;
            if (wr_done)                          count_d     = count_q + PTR_ONE;
            if (in_load && full && in_if.in_valid) overflow_d = 1'b1;
            if (accept && pk_err)                 field_err_d = 1'b1;
        end

        // Address/data only change on a new accept, so they hold steady while stalled.
        if (accept) begin
            out_vld_d  = 1'b1;
            out_addr_d = wr_ptr_q[ADDR_W-1:0];
            out_dat_d  = pk_byte;
        end else if (wr_done) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_vld_q   <= 1'b0;
            out_addr_q  <= '0;
            out_dat_q   <= '0;
            overflow_q  <= 1'b0;
            field_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_vld_q   <= out_vld_d;
            out_addr_q  <= out_addr_d;
            out_dat_q   <= out_dat_d;
            overflow_q  <= overflow_d;
            field_err_q <= field_err_d;
        end
    end

    assign in_if.in_ready   = in_rdy;
    assign mem_if.mem_we    = out_vld_q;
    assign mem_if.mem_addr  = out_addr_q;
    assign mem_if.mem_wdata = out_dat_q;
    assign busy_o           = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done_o           = (state_q == ST_DONE);
    assign count_o          = count_q;
    assign overflow_o       = overflow_q;
    assign field_err_o      = field_err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader with a 4-byte memory (ADDR_W=2).
// Driver pushes hand-computed {addr, byte} on each accepted tuple; monitor checks every mem_we cycle.
// Covers reset, encoding formats, field errors, stalls, overflow, finish-with-last-tuple, mid-session reset.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            finish;
    logic            busy;
    logic            done;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            field_err;

    instr_fields_if                   in_if ();
    instr_mem_if #(.ADDR_W(ADDR_W))   mem_if ();

    instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .finish_i    (finish),
        .in_if       (in_if),
        .mem_if      (mem_if),
        .busy_o      (busy),
        .done_o      (done),
        .count_o     (count),
        .overflow_o  (overflow),
        .field_err_o (field_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_ptr = 0;
    int last_acc_cyc = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [7:0]        exp_dat_q[$];
    int                wr_cyc_q[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every cycle a write is presented it must match the oldest expected beat;
    // the beat retires only when mem_ready completes it.
    always @(negedge clk) begin
        if (!rst && mem_if.mem_we) begin
            if (exp_dat_q.size() == 0) begin
                chk("unexpected_write", 32'(mem_if.mem_wdata), 32'hFFFF_FFFF);
            end else begin
                chk("wr_addr", 32'(mem_if.mem_addr),  32'(exp_addr_q[0]));
                chk("wr_data", 32'(mem_if.mem_wdata), 32'(exp_dat_q[0]));
                if (mem_if.mem_ready) begin
                    void'(exp_addr_q.pop_front());
                    void'(exp_dat_q.pop_front());
                    wr_cyc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_session();
        start = 1'b1;
        exp_ptr = 0;
        wr_cyc_q.delete();
        tick();
        start = 1'b0;
    endtask

    // Presents a tuple and waits for acceptance; in_valid is left high for the caller.
    task automatic offer(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] imm2, input logic [3:0] imm4, input logic [7:0] exp_byte);
        bit taken = 1'b0;
        in_if.in_valid  = 1'b1;
        in_if.in_opcode = op;
        in_if.in_rd     = rd;
        in_if.in_rs     = rs;
        in_if.in_imm2   = imm2;
        in_if.in_imm4   = imm4;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            if (in_if.in_ready) taken = 1'b1;
            tick();
        end
        if (taken) begin
            exp_addr_q.push_back(exp_ptr[ADDR_W-1:0]);
            exp_dat_q.push_back(exp_byte);
            exp_ptr++;
            last_acc_cyc = cyc;
        end else begin
            chk("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic drop();
        in_if.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_reached", 32'(seen), 32'd1);
        tick();
    endtask

    task automatic close_session();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        wait_done();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        finish = 1'b0;
        in_if.in_valid  = 1'b0;
        in_if.in_opcode = '0;
        in_if.in_rd     = '0;
        in_if.in_rs     = '0;
        in_if.in_imm2   = '0;
        in_if.in_imm4   = '0;
        mem_if.mem_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        chk("rst_in_ready",  32'(in_if.in_ready),    32'd0);
        chk("rst_mem_we",    32'(mem_if.mem_we),     32'd0);
        chk("rst_mem_addr",  32'(mem_if.mem_addr),   32'd0);
        chk("rst_mem_wdata", 32'(mem_if.mem_wdata),  32'd0);
        chk("rst_busy",      32'(busy),              32'd0);
        chk("rst_done",      32'(done),              32'd0);
        chk("rst_count",     32'(count),             32'd0);
        chk("rst_flags",     32'({overflow, field_err}), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Session 1: single IMM4 tuple, latency N+1
        open_session();
        chk("s1_busy", 32'(busy), 32'd1);
        offer(4'b0001, 2'd0, 2'd0, 2'd0, 4'b1010, 8'h1A);
        drop();
        tick();
        tick();
        chk("s1_latency", 32'(wr_cyc_q.size() > 0 ? wr_cyc_q[0] : -1), 32'(last_acc_cyc));
        chk("s1_count", 32'(count), 32'd1);
        chk("s1_field_err", 32'(field_err), 32'd0);
        close_session();

        // Session 2: RR then RI back-to-back
        open_session();
        offer(4'b0011, 2'd2, 2'd1, 2'd0, 4'd0, 8'h39);
        offer(4'b1100, 2'd3, 2'd0, 2'd2, 4'd0, 8'hCE);
        drop();
        tick();
        tick();
        chk("s2_b2b", 32'(wr_cyc_q.size() == 2 ? wr_cyc_q[1] - wr_cyc_q[0] : -1), 32'd1);
        chk("s2_count", 32'(count), 32'd2);
        close_session();

        // Session 3: unused field nonzero -> field_err, sticky through DONE
        open_session();
        offer(4'b0000, 2'd1, 2'd0, 2'd0, 4'd5, 8'h05);
        drop();
        tick();
        tick();
        chk("s3_field_err", 32'(field_err), 32'd1);
        close_session();
        chk("s3_field_err_done", 32'(field_err), 32'd1);
        chk("s3_done_held", 32'(done), 32'd1);

        // Session 4: stall for 3 cycles, next beat waits
        open_session();
        chk("s4_field_err_clr", 32'(field_err), 32'd0);
        mem_if.mem_ready = 1'b0;
        offer(4'b0101, 2'd1, 2'd3, 2'd0, 4'd0, 8'h57);
        in_if.in_opcode = 4'b1001;
        in_if.in_rd     = 2'd2;
        in_if.in_rs     = 2'd0;
        in_if.in_imm2   = 2'd1;
        in_if.in_imm4   = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s4_stall_rdy", 32'(in_if.in_ready), 32'd0);
            chk("s4_stall_we",  32'(mem_if.mem_we),  32'd1);
            tick();
        end
        mem_if.mem_ready = 1'b1;
        offer(4'b1001, 2'd2, 2'd0, 2'd1, 4'd0, 8'h99);
        drop();
        tick();
        tick();
        chk("s4_count", 32'(count), 32'd2);
        close_session();

        // Session 5: capacity 4, fifth tuple refused, overflow set
        open_session();
        offer(4'b0010, 2'd1, 2'd0, 2'd3, 4'd0, 8'h27);
        offer(4'b0111, 2'd3, 2'd0, 2'd0, 4'd0, 8'h7C);
        offer(4'b1111, 2'd0, 2'd0, 2'd2, 4'd0, 8'hF2);
        offer(4'b0000, 2'd0, 2'd0, 2'd0, 4'hF, 8'h0F);
        in_if.in_opcode = 4'b1010;
        in_if.in_rd     = 2'd1;
        in_if.in_rs     = 2'd1;
        in_if.in_imm2   = 2'd0;
        in_if.in_imm4   = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s5_full_rdy", 32'(in_if.in_ready), 32'd0);
            tick();
        end
        drop();
        tick();
        chk("s5_overflow", 32'(overflow), 32'd1);
        chk("s5_count", 32'(count), 32'd4);
        chk("s5_field_err", 32'(field_err), 32'd0);
        close_session();

        // Session 6: finish together with the last tuple
        open_session();
        chk("s6_overflow_clr", 32'(overflow), 32'd0);
        offer(4'b1011, 2'd2, 2'd0, 2'd0, 4'd0, 8'hB8);
        finish = 1'b1;
        offer(4'b1000, 2'd0, 2'd2, 2'd0, 4'd0, 8'h82);
        finish = 1'b0;
        drop();
        wait_done();
        chk("s6_count", 32'(count), 32'd2);
        chk("s6_sb_empty", 32'(exp_dat_q.size()), 32'd0);

        // Session 7: reset while a write is pending
        open_session();
        mem_if.mem_ready = 1'b0;
        offer(4'b0100, 2'd1, 2'd1, 2'd0, 4'd0, 8'h45);
        drop();
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("r7_in_ready",  32'(in_if.in_ready),   32'd0);
        chk("r7_mem_we",    32'(mem_if.mem_we),    32'd0);
        chk("r7_mem_addr",  32'(mem_if.mem_addr),  32'd0);
        chk("r7_mem_wdata", 32'(mem_if.mem_wdata), 32'd0);
        chk("r7_busy_done", 32'({busy, done}),     32'd0);
        chk("r7_count",     32'(count),            32'd0);
        chk("r7_flags",     32'({overflow, field_err}), 32'd0);
        exp_addr_q.delete();
        exp_dat_q.delete();
        tick();
        rst = 1'b0;
        mem_if.mem_ready = 1'b1;
        repeat (3) tick();
        chk("final_sb_empty", 32'(exp_dat_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog: a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
